// File: rtl/read2control_pkg.sv
// Shared definitions for the read2control buffer-to-stream reader:
// FSM states, default geometry and column pairing.
package read2control_pkg;

    localparam int X_MAC_DEF        = 4;
    localparam int X_MESH_DEF       = 16;
    localparam int ADDR_LEN_DEF     = 13;
    localparam int DATA_LEN_DEF     = 32;
    localparam int MAX_LINE_LEN_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_LAT  = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

    // In 2x2 mode the second column wraps, so column 3 pairs with column 0.
    function automatic logic [1:0] pair_col(input logic [1:0] mac);
        return mac + 2'd1;
    endfunction

endpackage

// File: rtl/read_unpack.sv
// Combinational lane selection: turns the latched buffer words into one
// output beat for the current slot, in single-byte or 2x2 layout.
module read_unpack
    import read2control_pkg::*;
#(
    parameter int X_MAC      = X_MAC_DEF,
    parameter int X_MESH     = X_MESH_DEF,
    parameter int DATA_LEN   = DATA_LEN_DEF,
    parameter int BUFFER_NUM = X_MAC * X_MESH
) (
    input  logic [BUFFER_NUM*DATA_LEN-1:0] word_i,
    input  logic [1:0]                     slot_i,
    input  logic                           pooled_i,
    input  logic [1:0]                     mac_i,
    input  logic                           en_i,
    output logic [8*X_MESH-1:0]            out_data_1_o,
    output logic [32*X_MESH-1:0]           out_data_4_o
);

    logic [1:0] col_b;

    assign col_b = pair_col(mac_i);

    always_comb begin
        logic [DATA_LEN-1:0] word_a;
        logic [DATA_LEN-1:0] word_b;
        out_data_1_o = '0;
        out_data_4_o = '0;
        word_a       = '0;
        word_b       = '0;
        if (en_i) begin
            for (int i = 0; i < X_MESH; i++) begin
                word_a = word_i[(int'(mac_i) + i*X_MAC)*DATA_LEN +: DATA_LEN];
                word_b = word_i[(int'(col_b) + i*X_MAC)*DATA_LEN +: DATA_LEN];
                if (pooled_i) begin
                    out_data_1_o[i*8 +: 8] = word_a[int'(slot_i)*8 +: 8];
                end else begin
                    // Row i carries two 16-bit halves: [i][0] from the first
                    // column, [i][1] from its partner column.
                    out_data_4_o[i*32      +: 16] = word_a[int'(slot_i[0])*16 +: 16];
                    out_data_4_o[i*32 + 16 +: 16] = word_b[int'(slot_i[0])*16 +: 16];
                end
            end
        end
    end

endmodule

// File: rtl/read2control.sv
// Reads one word per selected buffer column, latches it, then streams it out
// slot by slot under valid/ready until the configured line length is consumed.
module read2control
    import read2control_pkg::*;
#(
    parameter int X_MAC        = X_MAC_DEF,
    parameter int X_MESH       = X_MESH_DEF,
    parameter int ADDR_LEN     = ADDR_LEN_DEF,
    parameter int DATA_LEN     = DATA_LEN_DEF,
    parameter int MAX_LINE_LEN = MAX_LINE_LEN_DEF,
    parameter int BUFFER_NUM   = X_MAC * X_MESH,
    parameter int ADDRWIDTH    = BUFFER_NUM * ADDR_LEN,
    parameter int DATAWIDTH    = BUFFER_NUM * DATA_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      conf_input,
    input  logic [ADDR_LEN*X_MAC-1:0] st_addr,
    input  logic [MAX_LINE_LEN-1:0]   linelen,
    input  logic [1:0]                valid_mac,
    input  logic                      pooled,
    output logic [ADDRWIDTH-1:0]      addrb,
    output logic [BUFFER_NUM-1:0]     enb,
    input  logic [DATAWIDTH-1:0]      doutb,
    output logic [8*X_MESH-1:0]       out_data_1,
    output logic [32*X_MESH-1:0]      out_data_4,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      idle,
    output logic                      busy
);

    state_t                    state_q, state_d;
    logic [1:0]                mac_q, mac_d;
    logic                      pooled_q, pooled_d;
    logic [MAX_LINE_LEN-1:0]   remain_q, remain_d;
    logic [ADDR_LEN*X_MAC-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0]      word_q, word_d;
    logic [1:0]                slot_q, slot_d;

    logic [X_MAC-1:0]          col_sel;
    logic [MAX_LINE_LEN-1:0]   remain_next;
    logic                      last_slot;
    logic                      accept;

    always_comb begin
        col_sel = '0;
        for (int j = 0; j < X_MAC; j++) begin
            col_sel[j] = (2'(j) == mac_q) || (!pooled_q && (2'(j) == pair_col(mac_q)));
        end
    end

    // 2x2 mode consumes two elements per slot; an odd tail saturates at zero.
    always_comb begin
        if (pooled_q) begin
            remain_next = remain_q - MAX_LINE_LEN'(1);
        end else if (remain_q >= MAX_LINE_LEN'(2)) begin
            remain_next = remain_q - MAX_LINE_LEN'(2);
        end else begin
            remain_next = '0;
        end
    end

    assign last_slot = pooled_q ? (slot_q == 2'd3) : (slot_q == 2'd1);
    assign accept    = (state_q == ST_EMIT) && out_ready;

    always_comb begin
        state_d  = state_q;
        mac_d    = mac_q;
        pooled_d = pooled_q;
        remain_d = remain_q;
        addr_d   = addr_q;
        word_d   = word_q;
        slot_d   = slot_q;
        enb      = '0;
        addrb    = '0;
        case (state_q)
            ST_IDLE: begin
                if (conf_input && (linelen != '0)) begin
                    mac_d    = valid_mac;
                    pooled_d = pooled;
                    remain_d = linelen;
                    addr_d   = st_addr;
                    slot_d   = '0;
                    state_d  = ST_RD;
                end
            end
            ST_RD: begin
                for (int i = 0; i < X_MESH; i++) begin
                    for (int j = 0; j < X_MAC; j++) begin
                        enb[j + i*X_MAC] = col_sel[j];
                        addrb[(j + i*X_MAC)*ADDR_LEN +: ADDR_LEN] = addr_q[j*ADDR_LEN +: ADDR_LEN];
                    end
                end
                state_d = ST_LAT;
            end
            ST_LAT: begin
                word_d  = doutb;
                slot_d  = '0;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (accept) begin
                    remain_d = remain_next;
                    if (remain_next == '0) begin
                        state_d = ST_IDLE;
                    end else if (last_slot) begin
                        for (int j = 0; j < X_MAC; j++) begin
                            addr_d[j*ADDR_LEN +: ADDR_LEN] = addr_q[j*ADDR_LEN +: ADDR_LEN] + ADDR_LEN'(1);
                        end
                        state_d = ST_RD;
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mac_q    <= '0;
            pooled_q <= 1'b0;
            remain_q <= '0;
            addr_q   <= '0;
            word_q   <= '0;
            slot_q   <= '0;
        end else begin
            state_q  <= state_d;
            mac_q    <= mac_d;
            pooled_q <= pooled_d;
            remain_q <= remain_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            slot_q   <= slot_d;
        end
    end

    assign out_valid = (state_q == ST_EMIT);
    assign idle      = (state_q == ST_IDLE);
    assign busy      = !idle;

    read_unpack #(
        .X_MAC      (X_MAC),
        .X_MESH     (X_MESH),
        .DATA_LEN   (DATA_LEN),
        .BUFFER_NUM (BUFFER_NUM)
    ) u_unpack (
        .word_i       (word_q),
        .slot_i       (slot_q),
        .pooled_i     (pooled_q),
        .mac_i        (mac_q),
        .en_i         (out_valid),
        .out_data_1_o (out_data_1),
        .out_data_4_o (out_data_4)
    );

endmodule

// File: tb/tb_read2control.sv
// Directed bench for read2control: BRAM model, expected-beat scoreboard and
// a monitor that checks every accepted beat.
module tb_read2control;

    logic          clk = 1'b0;
    logic          rst;
    logic          conf_input;
    logic [51:0]   st_addr;
    logic [9:0]    linelen;
    logic [1:0]    valid_mac;
    logic          pooled;
    logic [831:0]  addrb;
    logic [63:0]   enb;
    logic [2047:0] doutb = '0;
    logic [127:0]  out_data_1;
    logic [511:0]  out_data_4;
    logic          out_valid;
    logic          out_ready;
    logic          idle;
    logic          busy;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [127:0] d1;
        logic [511:0] d4;
    } exp_t;
    exp_t exp_q[$];

    typedef struct packed {
        logic [3:0]       cols;
        logic             allrows;
        logic [3:0][12:0] a;
    } rd_t;
    rd_t rd_q[$];

    logic [31:0] mem [int];

    read2control dut (
        .clk        (clk),
        .rst        (rst),
        .conf_input (conf_input),
        .st_addr    (st_addr),
        .linelen    (linelen),
        .valid_mac  (valid_mac),
        .pooled     (pooled),
        .addrb      (addrb),
        .enb        (enb),
        .doutb      (doutb),
        .out_data_1 (out_data_1),
        .out_data_4 (out_data_4),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .idle       (idle),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rdmem(input int j, input logic [12:0] a);
        int key;
        key = j*8192 + int'(a);
        if (mem.exists(key)) return mem[key];
        return 32'h0;
    endfunction

    // Each row sees the column word with the row index added to every byte.
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (enb[j + i*4]) begin
                    doutb[(j + i*4)*32 +: 32] <= rdmem(j, addrb[(j + i*4)*13 +: 13]) + 32'h01010101 * 32'(i);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && (|enb)) begin
            rd_t r;
            r.cols    = enb[3:0];
            r.allrows = (enb == {16{enb[3:0]}});
            for (int j = 0; j < 4; j++) r.a[j] = addrb[j*13 +: 13];
            rd_q.push_back(r);
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 512'(1), 512'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("beat_d1", 512'(out_data_1), 512'(e.d1));
                chk("beat_d4", out_data_4, e.d4);
            end
        end
    end

    function automatic logic [127:0] pooled_beat(input logic [7:0] b);
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = b + 8'(i);
        return d;
    endfunction

    task automatic push_pooled(input logic [7:0] b);
        exp_t e;
        e.d1 = pooled_beat(b);
        e.d4 = '0;
        exp_q.push_back(e);
    endtask

    // a0,a1: bytes of [i][0]; b0,b1: bytes of [i][1]
    task automatic push_np(input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] b0, input logic [7:0] b1);
        exp_t e;
        e.d1 = '0;
        for (int i = 0; i < 16; i++)
            e.d4[i*32 +: 32] = {b1 + 8'(i), b0 + 8'(i), a1 + 8'(i), a0 + 8'(i)};
        exp_q.push_back(e);
    endtask

    task automatic start(input logic p, input logic [1:0] m,
                         input logic [12:0] a0, input logic [12:0] a1,
                         input logic [12:0] a2, input logic [12:0] a3,
                         input logic [9:0] len);
        @(negedge clk);
        pooled     = p;
        valid_mac  = m;
        st_addr    = {a3, a2, a1, a0};
        linelen    = len;
        conf_input = 1'b1;
        @(negedge clk);
        conf_input = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (idle) return;
        end
        chk({nm, "_idle_timeout"}, 512'(0), 512'(1));
    endtask

    task automatic wait_valid(input string nm, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        chk({nm, "_valid_timeout"}, 512'(0), 512'(1));
    endtask

    task automatic check_read(input string nm, input int idx, input logic [3:0] cols,
                              input int col, input logic [12:0] addr);
        if (idx >= rd_q.size()) begin
            chk({nm, "_missing_read"}, 512'(rd_q.size()), 512'(idx + 1));
        end else begin
            chk({nm, "_cols"}, 512'(rd_q[idx].cols), 512'(cols));
            chk({nm, "_allrows"}, 512'(rd_q[idx].allrows), 512'(1));
            chk({nm, "_addr"}, 512'(rd_q[idx].a[col]), 512'(addr));
        end
    endtask

    initial begin
        rst        = 1'b1;
        conf_input = 1'b0;
        st_addr    = '0;
        linelen    = '0;
        valid_mac  = '0;
        pooled     = 1'b0;
        out_ready  = 1'b0;

        mem[1*8192 + 5]    = 32'h44332211;
        mem[1*8192 + 6]    = 32'h88776655;
        mem[3*8192 + 20]   = 32'hDDCCBBAA;
        mem[0*8192 + 30]   = 32'h44332211;
        mem[0*8192 + 100]  = 32'h04030201;
        mem[0*8192 + 101]  = 32'h08070605;
        mem[1*8192 + 200]  = 32'h14131211;
        mem[1*8192 + 201]  = 32'h18171615;
        mem[2*8192 + 7]    = 32'hA4A3A2A1;
        mem[0*8192 + 8191] = 32'h04030201;
        mem[0*8192 + 0]    = 32'h08070605;

        repeat (3) @(negedge clk);
        chk("rst_idle", 512'(idle), 512'(1));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_valid", 512'(out_valid), 512'(0));
        chk("rst_enb", 512'(enb), 512'(0));
        chk("rst_addrb_zero", 512'(addrb == '0), 512'(1));
        chk("rst_d1", 512'(out_data_1), 512'(0));
        chk("rst_d4", out_data_4, 512'(0));
        rst = 1'b0;

        // linelen=0 is ignored
        start(1'b1, 2'd1, 13'd0, 13'd5, 13'd0, 13'd0, 10'd0);
        repeat (2) @(negedge clk);
        chk("len0_idle", 512'(idle), 512'(1));
        chk("len0_reads", 512'(rd_q.size()), 512'(0));

        // Pooled, column 1, two words, with latency check
        rd_q.delete();
        out_ready = 1'b1;
        for (int b = 1; b <= 6; b++) push_pooled(8'(b * 8'h11));
        @(negedge clk);
        pooled = 1'b1; valid_mac = 2'd1; st_addr = {13'd0, 13'd0, 13'd5, 13'd0};
        linelen = 10'd6; conf_input = 1'b1;
        @(posedge clk); #1;
        conf_input = 1'b0;
        chk("lat_enb_c1", 512'(enb[3:0]), 512'(4'b0010));
        chk("lat_busy_c1", 512'(busy), 512'(1));
        chk("lat_valid_c1", 512'(out_valid), 512'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lat_valid_emit", 512'(out_valid), 512'(1));
        wait_idle("t1", 60);
        check_read("t1_rd0", 0, 4'b0010, 1, 13'd5);
        check_read("t1_rd1", 1, 4'b0010, 1, 13'd6);
        chk("t1_nreads", 512'(rd_q.size()), 512'(2));
        chk("t1_drain", 512'(exp_q.size()), 512'(0));

        // 2x2, column 3 paired with column 0
        rd_q.delete();
        push_np(8'hAA, 8'hBB, 8'h11, 8'h22);
        push_np(8'hCC, 8'hDD, 8'h33, 8'h44);
        start(1'b0, 2'd3, 13'd30, 13'd0, 13'd0, 13'd20, 10'd4);
        wait_idle("t2", 60);
        check_read("t2_rd0_c3", 0, 4'b1001, 3, 13'd20);
        check_read("t2_rd0_c0", 0, 4'b1001, 0, 13'd30);
        chk("t2_nreads", 512'(rd_q.size()), 512'(1));
        chk("t2_drain", 512'(exp_q.size()), 512'(0));

        // 2x2, odd length: second word emits only its low half
        rd_q.delete();
        push_np(8'h01, 8'h02, 8'h11, 8'h12);
        push_np(8'h03, 8'h04, 8'h13, 8'h14);
        push_np(8'h05, 8'h06, 8'h15, 8'h16);
        start(1'b0, 2'd0, 13'd100, 13'd200, 13'd0, 13'd0, 10'd5);
        wait_idle("t3", 60);
        check_read("t3_rd0", 0, 4'b0011, 0, 13'd100);
        check_read("t3_rd1", 1, 4'b0011, 1, 13'd201);
        chk("t3_nreads", 512'(rd_q.size()), 512'(2));
        chk("t3_drain", 512'(exp_q.size()), 512'(0));

        // Back-pressure for 5 cycles after the first beat
        rd_q.delete();
        push_pooled(8'hA1); push_pooled(8'hA2); push_pooled(8'hA3); push_pooled(8'hA4);
        start(1'b1, 2'd2, 13'd0, 13'd0, 13'd7, 13'd0, 10'd4);
        wait_valid("t4", 20);
        @(posedge clk); #2;
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("stall_valid", 512'(out_valid), 512'(1));
            chk("stall_d1", 512'(out_data_1), 512'(pooled_beat(8'hA2)));
            chk("stall_enb", 512'(enb), 512'(0));
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_idle("t4", 60);
        chk("t4_nreads", 512'(rd_q.size()), 512'(1));
        chk("t4_drain", 512'(exp_q.size()), 512'(0));

        // Address wrap from 8191 to 0
        rd_q.delete();
        for (int b = 1; b <= 8; b++) push_pooled(8'(b));
        start(1'b1, 2'd0, 13'd8191, 13'd0, 13'd0, 13'd0, 10'd8);
        wait_idle("t5", 80);
        check_read("t5_rd0", 0, 4'b0001, 0, 13'd8191);
        check_read("t5_rd1", 1, 4'b0001, 0, 13'd0);
        chk("t5_drain", 512'(exp_q.size()), 512'(0));

        // Ignored re-config during a run, then reset mid-emit
        rd_q.delete();
        out_ready = 1'b0;
        start(1'b1, 2'd1, 13'd0, 13'd5, 13'd0, 13'd0, 10'd6);
        wait_valid("t6", 20);
        pooled = 1'b0; valid_mac = 2'd0; linelen = 10'd2; conf_input = 1'b1;
        @(negedge clk);
        conf_input = 1'b0;
        chk("reconf_valid", 512'(out_valid), 512'(1));
        chk("reconf_d1", 512'(out_data_1), 512'(pooled_beat(8'h11)));
        chk("reconf_nreads", 512'(rd_q.size()), 512'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", 512'(out_valid), 512'(0));
        chk("mid_rst_idle", 512'(idle), 512'(1));
        chk("mid_rst_busy", 512'(busy), 512'(0));
        chk("mid_rst_d1", 512'(out_data_1), 512'(0));
        chk("mid_rst_d4", out_data_4, 512'(0));
        chk("mid_rst_enb", 512'(enb), 512'(0));
        @(negedge clk);
        // reset and start together: reset wins
        pooled = 1'b1; valid_mac = 2'd1; linelen = 10'd6; conf_input = 1'b1;
        @(negedge clk);
        rst = 1'b0; conf_input = 1'b0;
        @(negedge clk);
        chk("rst_conf_idle", 512'(idle), 512'(1));
        chk("rst_conf_enb", 512'(enb), 512'(0));
        chk("t6_drain", 512'(exp_q.size()), 512'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
